dl_prom: RTL and testbench
==========================

// Module: dl_prom
// PURPOSE
//   Parametrised synchronous PROM (state-machine/colour PROMs) whose contents are loaded at run
//   time from the HPS ioctl download stream rather than fixed in RTL.
//   Sits between the top-level ioctl bus and the vector-generator / video logic.
//   Replaces per-PROM hard-coded case tables.
//   Adds load tracking, load-error detection, read gating during load and an optional output register.
// PARAMETERS
//   ADDR_W    8        word address width; DEPTH = 2**ADDR_W
//   DATA_W    4        word width, 1..8; takes the low DATA_W bits of each download byte
//   IDX       8'd0     ioctl_index value that selects this PROM
//   BASE      25'h0    ioctl byte address of word 0
//   OUT_REG   1        1: extra output register (read latency 2); 0: read latency 1
// PORTS
//   clk            in   1       system clock
//   reset          in   1       synchronous, active-high reset
//   ioctl_download in   1       HPS download active
//   ioctl_index    in   8       download target index
//   ioctl_wr       in   1       one-cycle byte strobe
//   ioctl_addr     in   25      byte address
//   ioctl_dout     in   8       byte data
//   addr           in   ADDR_W  read address
//   cs             in   1       read enable
//   dout           out  DATA_W  read data
//   dout_valid     out  1       dout holds data from a cs read of a loaded PROM
//   loaded         out  1       PROM contents complete and valid
//   load_err       out  1       last download ended with fewer than DEPTH in-window writes
// BEHAVIOUR
//   Reset values
//   - dout=0, dout_valid=0, loaded=0, load_err=0, state=IDLE, wcount=0.
//   - Memory contents are not cleared by reset.
//   - The previous-download flag resets to 1, so a download already in progress at reset is
//     ignored until ioctl_download falls.
//   Selection and window
//   - sel = (ioctl_index==IDX).
//   - in_win = ioctl_addr in [BASE, BASE+DEPTH-1].
//   - Word address = ioctl_addr-BASE, truncated to ADDR_W bits.
//   FSM
//   - IDLE -> LOAD on an ioctl_download rise (1 now, 0 last cycle) with sel.
//     On this transition: wcount=0, loaded=0, load_err=0.
//   - LOAD: each ioctl_wr with in_win writes ioctl_dout[DATA_W-1:0] to mem at the word address.
//     wcount increments, saturating at DEPTH.
//     Duplicate addresses are counted.
//     Writes outside the window, or while not in LOAD, are ignored.
//   - LOAD -> IDLE when ioctl_download=0.
//     Same cycle: loaded <= (wcount==DEPTH); load_err <= (wcount!=DEPTH).
//     A write in the final LOAD cycle is counted before this compare.
//   - A download with a non-matching index never leaves IDLE; loaded and load_err are unchanged.
//   Read path
//   - Stage 1: when cs=1, r1 <= mem[addr] and v1 <= loaded & (state==IDLE).
//     When cs=0, r1 holds and v1 <= 0.
//   - OUT_REG=0: dout=r1, dout_valid=v1 (valid 1 clk after the cs edge).
//   - OUT_REG=1: dout/dout_valid are registered again from r1/v1 (valid 2 clks after).
//   - Reads during LOAD return the memory array contents with dout_valid=0.
//     The read port never stalls the write port.
//   Reset mid-download
//   - Forces IDLE with loaded=0.
//   - Bytes already written stay in memory but are not trusted until a full reload.
// TESTING
//   1. Index IDX, bytes 0x00..0xFF at BASE..BASE+255, then download falls
//      -> loaded=1, load_err=0.
//      Then cs=1, addr=0x4A -> dout=4'hA with dout_valid=1 two clks later (OUT_REG=1).
//   2. Same load but only 255 bytes -> loaded=0, load_err=1; every read gives dout_valid=0.
//   3. Extra writes at BASE-1 and BASE+256 during a full load
//      -> wcount ends at 256; mem[0]/mem[255] hold the in-window values.
//   4. Download with ioctl_index=IDX+1 -> state stays IDLE, mem unchanged, loaded keeps its old value.
//   5. Reset asserted after 100 bytes while download stays high -> no further writes, loaded=0.
//      Next full download -> loaded=1.
//   6. cs=1 for addr 0x10, then cs=0 with addr changed -> dout holds the 0x10 data
//      and dout_valid drops after the latency.

Source files
------------

// File: rtl/dl_prom_if.sv
// ioctl download bus plus PROM read port, bundled for dl_prom.
// The master side is the HPS/ioctl and read requester; the slave side is the PROM.
interface dl_prom_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
);
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [ADDR_W-1:0] addr;
   logic              cs;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              loaded;
   logic              load_err;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, addr, cs,
      input  dout, dout_valid, loaded, load_err
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, addr, cs,
      output dout, dout_valid, loaded, load_err
   );
endinterface

// File: rtl/dl_prom.sv
// Run-time loadable PROM fed from the ioctl download stream; read latency 1 (OUT_REG=0) or 2.
// Never stalls: reads during a load return raw array contents with dout_valid low.
module dl_prom #(
   parameter int          ADDR_W  = 8,
   parameter int          DATA_W  = 4,
   parameter logic [7:0]  IDX     = 8'd0,
   parameter logic [24:0] BASE    = 25'h0,
   parameter bit          OUT_REG = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   dl_prom_if.slave  bus
);
   localparam int          DEPTH  = 2 ** ADDR_W;
   localparam int          CNT_W  = ADDR_W + 1;
   localparam logic [25:0] WIN_LO = {1'b0, BASE};
   localparam logic [25:0] WIN_HI = WIN_LO + 26'(DEPTH) - 26'd1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t            state_q, state_d;
   logic              dl_q;
   logic [CNT_W-1:0]  wcount_q, wcount_d, wcount_inc;
   logic              loaded_q, loaded_d;
   logic              load_err_q, load_err_d;
   logic              sel, in_win, dl_rise, we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] r1_q;
   logic              v1_q;

   assign sel     = (bus.ioctl_index == IDX);
   assign in_win  = ({1'b0, bus.ioctl_addr} >= WIN_LO) && ({1'b0, bus.ioctl_addr} <= WIN_HI);
   assign dl_rise = bus.ioctl_download & ~dl_q;
   assign waddr   = ADDR_W'(bus.ioctl_addr - BASE);
   assign wdata   = DATA_W'(bus.ioctl_dout);

   always_comb begin
      state_d    = state_q;
      wcount_d   = wcount_q;
      wcount_inc = wcount_q;
      loaded_d   = loaded_q;
      load_err_d = load_err_q;
      we         = 1'b0;
      case (state_q)
         IDLE: begin
            if (dl_rise && sel) begin
               state_d    = LOAD;
               wcount_d   = '0;
               loaded_d   = 1'b0;
               load_err_d = 1'b0;
            end
         end
         LOAD: begin
            we = bus.ioctl_wr & in_win;
            if (we && (wcount_q != CNT_W'(DEPTH)))
               wcount_inc = wcount_q + 1'b1;
            wcount_d = wcount_inc;
            // The closing write is folded into the count before the completeness test.
            if (!bus.ioctl_download) begin
               state_d    = IDLE;
               loaded_d   = (wcount_inc == CNT_W'(DEPTH));
               load_err_d = (wcount_inc != CNT_W'(DEPTH));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // dl_q resets high so a download already running at reset is not mistaken for a new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dl_q       <= 1'b1;
         wcount_q   <= '0;
         loaded_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= bus.ioctl_download;
         wcount_q   <= wcount_d;
         loaded_q   <= loaded_d;
         load_err_q <= load_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we && !reset)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         if (bus.cs)
            r1_q <= mem[bus.addr];
         v1_q <= bus.cs & loaded_q & (state_q == IDLE);
      end
   end

   generate
      if (OUT_REG) begin : g_oreg
         logic [DATA_W-1:0] dout_q;
         logic              vld_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               dout_q <= r1_q;
               vld_q  <= v1_q;
            end
         end
         assign bus.dout       = dout_q;
         assign bus.dout_valid = vld_q;
      end else begin : g_noreg
         assign bus.dout       = r1_q;
         assign bus.dout_valid = v1_q;
      end
   endgenerate

   assign bus.loaded   = loaded_q;
   assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_dl_prom.sv
// Bench for dl_prom: directed downloads, read responses checked by a queue-based monitor.
module tb_dl_prom;
   localparam logic [7:0]  IDX  = 8'd3;
   localparam logic [24:0] BASE = 25'h1000;
   localparam int          B    = 32'h1000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dl_prom_if #(.ADDR_W(8), .DATA_W(4)) bus ();

   dl_prom #(
      .ADDR_W(8), .DATA_W(4), .IDX(IDX), .BASE(BASE), .OUT_REG(1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   logic [4:0] expq [$];
   logic [4:0] e;
   logic       cs_p1 = 1'b0;
   logic       cs_p2 = 1'b0;

   // Read responses appear two clocks after the cs cycle.
   always @(posedge clk) begin
      cs_p1 <= bus.cs;
      cs_p2 <= cs_p1;
   end

   always @(negedge clk) begin
      if (cs_p2) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected dout=%h vld=%b with empty queue", bus.dout, bus.dout_valid);
         end else begin
            e = expq.pop_front();
            if ({bus.dout_valid, bus.dout} !== e) begin
               errors++;
               $display("FAIL rd got dout=%h vld=%b expected dout=%h vld=%b",
                        bus.dout, bus.dout_valid, e[3:0], e[4]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gen(input int kind, input int i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(i + 3);
         2:       return 8'(i * 3);
         3:       return 8'(i + (i >> 4));
         4:       return 8'(255 - i);
         5:       return 8'(i ^ 12);
         default: return 8'(i ^ 5);
      endcase
   endfunction

   task automatic wr(input int a, input logic [7:0] d);
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      cyc();
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic dl_start(input logic [7:0] idx);
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      cyc();
   endtask

   task automatic dl_end();
      bus.ioctl_download = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic load(input logic [7:0] idx, input int kind, input int n);
      dl_start(idx);
      for (int i = 0; i < n; i++) wr(B + i, gen(kind, i));
      dl_end();
   endtask

   task automatic rd(input int a, input logic [3:0] d, input logic v);
      bus.cs   = 1'b1;
      bus.addr = 8'(a);
      expq.push_back({v, d});
      cyc();
      bus.cs = 1'b0;
      cyc();
      cyc();
      cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      bus.addr           = '0;
      bus.cs             = 1'b0;
      reset              = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_dout", 8'(bus.dout), 8'h0);
      chk("rst_vld", 8'(bus.dout_valid), 8'h0);
      chk("rst_loaded", 8'(bus.loaded), 8'h0);
      chk("rst_err", 8'(bus.load_err), 8'h0);
      cyc();

      // Full load, data = byte address low nibble.
      load(IDX, 0, 256);
      chk("t1_loaded", 8'(bus.loaded), 8'h1);
      chk("t1_err", 8'(bus.load_err), 8'h0);
      rd(8'h4A, 4'hA, 1'b1);
      rd(8'h00, 4'h0, 1'b1);
      rd(8'hFF, 4'hF, 1'b1);

      // One byte short: data = i+3 for 0..254; word 0xFF keeps 0xF.
      load(IDX, 1, 255);
      chk("t2_loaded", 8'(bus.loaded), 8'h0);
      chk("t2_err", 8'(bus.load_err), 8'h1);
      rd(8'h10, 4'h3, 1'b0);
      rd(8'hFF, 4'hF, 1'b0);

      // Full load data = i*3, stray writes outside the window afterwards.
      dl_start(IDX);
      for (int i = 0; i < 256; i++) wr(B + i, gen(2, i));
      wr(B + 256, 8'h09);
      wr(B - 1, 8'h07);
      dl_end();
      chk("t3_loaded", 8'(bus.loaded), 8'h1);
      chk("t3_err", 8'(bus.load_err), 8'h0);
      rd(8'h00, 4'h0, 1'b1);
      rd(8'hFF, 4'hD, 1'b1);

      // Foreign index must leave everything alone.
      load(IDX + 8'd1, 4, 256);
      chk("t4_loaded", 8'(bus.loaded), 8'h1);
      chk("t4_err", 8'(bus.load_err), 8'h0);
      rd(8'h4A, 4'hE, 1'b1);

      // 255 in-window (i^5) plus two out-of-window writes: still short.
      dl_start(IDX);
      for (int i = 0; i < 255; i++) wr(B + i, gen(6, i));
      wr(B - 1, 8'h07);
      wr(B + 256, 8'h09);
      dl_end();
      chk("t3b_loaded", 8'(bus.loaded), 8'h0);
      chk("t3b_err", 8'(bus.load_err), 8'h1);
      rd(8'h4A, 4'hF, 1'b0);
      rd(8'hFF, 4'hD, 1'b0);

      // Reset after 100 bytes (i^12) while download stays high.
      dl_start(IDX);
      for (int i = 0; i < 100; i++) wr(B + i, gen(5, i));
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 100; i < 150; i++) wr(B + i, 8'h0F);
      chk("t5_loaded_mid", 8'(bus.loaded), 8'h0);
      rd(120, 4'hD, 1'b0);
      dl_end();
      chk("t5_loaded", 8'(bus.loaded), 8'h0);
      chk("t5_err", 8'(bus.load_err), 8'h0);
      rd(50, 4'hE, 1'b0);
      rd(120, 4'hD, 1'b0);
      load(IDX, 3, 256);
      chk("t5_reload", 8'(bus.loaded), 8'h1);
      chk("t5_reload_err", 8'(bus.load_err), 8'h0);

      // Hold behaviour: data i+(i>>4) gives 1 at 0x10 and 2 at 0x20.
      bus.cs   = 1'b1;
      bus.addr = 8'h10;
      expq.push_back({1'b1, 4'h1});
      cyc();
      bus.cs   = 1'b0;
      bus.addr = 8'h20;
      cyc();
      cyc();
      cyc();
      @(negedge clk);
      chk("t6_hold_dout", 8'(bus.dout), 8'h1);
      chk("t6_vld_drop", 8'(bus.dout_valid), 8'h0);
      cyc();
      cyc();
      chk("t6_hold_dout2", 8'(bus.dout), 8'h1);

      chk("queue_empty", 8'(expq.size()), 8'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
